// File: rtl/seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg_scan_decoder
//
// Purpose:
//   Snoops a multiplexed 8-digit 7-segment display bus (active-low anodes and
//   cathodes), waits for each anode selection to settle, decodes the lit
//   segment pattern of the selected digit into a 5-bit code and assembles a
//   full 8-digit frame.  Completed frames are presented with a valid/ready
//   handshake.  A frame that completes while the previous one is still
//   pending is dropped and flagged with a sticky overrun.
//
// Ports:
//   clk_100MHz   in   1   system clock, rising edge
//   reset        in   1   asynchronous reset, active low
//   anodes       in   8   display anodes, active low, AN7..AN0
//   cathodes     in   8   segment lines, active low, a,b,c,d,e,f,g,dp
//   frame_ready  in   1   consumer accepts the held frame
//   frame_valid  out  1   a complete frame is held on digit_codes/dp_bits
//   digit_codes  out 40   5-bit code per digit, [5i+4:5i] = AN(i)
//   dp_bits      out  8   decimal point per digit, 1 = lit
//   anode_error  out  1   one-cycle pulse: several anodes low at sample time
//   overrun      out  1   sticky: a completed frame was dropped
//
// Parameter:
//   SETTLE_CYCLES  stable cycles required before sampling (2..255)
//
// Configuration macro:
//   SEG_SCAN_DP_CAPTURE_EN  when defined, decimal points are captured into
//   dp_bits; otherwise dp_bits is tied to zero and no dp storage exists.
//
// Codes: 0-9 digits, 10 blank, 11 dash, 12 'E', 31 unrecognised pattern.
// ---------------------------------------------------------------------------
module seg_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES = 32'd16
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic [7:0]  anodes,
    input  logic [7:0]  cathodes,
    input  logic        frame_ready,
    output logic        frame_valid,
    output logic [39:0] digit_codes,
    output logic [7:0]  dp_bits,
    output logic        anode_error,
    output logic        overrun
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Counter value on the cycle in which the hold reaches SETTLE_CYCLES
    // (the entry cycle itself counts as the first stable cycle).
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 32'd1);
    localparam logic [4:0]  CODE_BLANK  = 5'd10;
    localparam logic [39:0] CODES_BLANK = {8{CODE_BLANK}};

    // Decode the active-low cathode byte; the dp bit (bit 0) is a wildcard.
    function automatic logic [4:0] decode_segments(input logic [7:0] cath);
        logic [4:0] code;
        casez (cath)
            8'b0000001?: code = 5'd0;
            8'b1001111?: code = 5'd1;
            8'b0010010?: code = 5'd2;
            8'b0000110?: code = 5'd3;
            8'b1001100?: code = 5'd4;
            8'b0100100?: code = 5'd5;
            8'b0100000?: code = 5'd6;
            8'b0001111?: code = 5'd7;
            8'b0000000?: code = 5'd8;
            8'b0000100?: code = 5'd9;
            8'b1111111?: code = 5'd10;
            8'b1111110?: code = 5'd11;
            8'b0110000?: code = 5'd12;
            default:     code = 5'd31;
        endcase
        return code;
    endfunction

    // True when exactly one active-low anode bit is asserted.
    function automatic logic single_low(input logic [7:0] an);
        logic [7:0] low;
        low = ~an;
        return (low != 8'h00) && ((low & (low - 8'h01)) == 8'h00);
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [7:0]  anodes_meta_r;
    logic [7:0]  anodes_sync_r;
    logic [7:0]  anodes_prev_r;
    logic [7:0]  cathodes_meta_r;
    logic [7:0]  cathodes_sync_r;
    logic [7:0]  settle_cnt_r;
    logic [7:0]  capture_mask_r;
    logic [39:0] shadow_codes_r;
    logic [39:0] digit_codes_r;
    logic        frame_valid_r;
    logic        anode_error_r;
    logic        overrun_r;

    logic        anode_changed_s;
    logic        count_done_s;
    logic        cnt_load_s;
    logic        cnt_inc_s;
    logic        sample_s;
    logic        err_sample_s;
    logic        frame_done_s;
    logic        frame_load_s;
    logic [7:0]  slot_we_s;
    logic [4:0]  code_s;

    // Two-flop synchronizers for the asynchronous display bus.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            anodes_meta_r   <= 8'hFF;
            anodes_sync_r   <= 8'hFF;
            anodes_prev_r   <= 8'hFF;
            cathodes_meta_r <= 8'hFF;
            cathodes_sync_r <= 8'hFF;
        end else begin
            anodes_meta_r   <= anodes;
            anodes_sync_r   <= anodes_meta_r;
            anodes_prev_r   <= anodes_sync_r;
            cathodes_meta_r <= cathodes;
            cathodes_sync_r <= cathodes_meta_r;
        end
    end

    // In SETTLE/HOLD the previous synchronized value is the value being held,
    // so a change against it is a change of the selection.
    assign anode_changed_s = (anodes_sync_r != anodes_prev_r);
    assign count_done_s    = (settle_cnt_r == SETTLE_LAST);
    assign frame_done_s    = (capture_mask_r == 8'hFF);
    assign frame_load_s    = frame_done_s && (!frame_valid_r || frame_ready);
    assign code_s          = decode_segments(cathodes_sync_r);

    // FSM state register.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (anodes_sync_r != 8'hFF) begin
                    state_next_s = ST_SETTLE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (anode_changed_s) begin
                    if (anodes_sync_r == 8'hFF) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_SETTLE;
                    end
                end else if (count_done_s) begin
                    state_next_s = ST_HOLD;
                end else begin
                    state_next_s = ST_SETTLE;
                end
            end
            ST_HOLD: begin
                if (anode_changed_s) begin
                    if (anodes_sync_r == 8'hFF) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_SETTLE;
                    end
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: counter control and sample strobe.
    always_comb begin
        cnt_load_s = 1'b0;
        cnt_inc_s  = 1'b0;
        sample_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_load_s = (anodes_sync_r != 8'hFF);
            end
            ST_SETTLE: begin
                if (anode_changed_s) begin
                    cnt_load_s = (anodes_sync_r != 8'hFF);
                end else if (count_done_s) begin
                    sample_s = 1'b1;
                end else begin
                    cnt_inc_s = 1'b1;
                end
            end
            ST_HOLD: begin
                if (anode_changed_s) begin
                    cnt_load_s = (anodes_sync_r != 8'hFF);
                end else begin
                    cnt_load_s = 1'b0;
                end
            end
            default: begin
                cnt_load_s = 1'b0;
            end
        endcase
    end

    // Settle counter.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            settle_cnt_r <= 8'd0;
        end else if (cnt_load_s) begin
            settle_cnt_r <= 8'd1;
        end else if (cnt_inc_s) begin
            settle_cnt_r <= settle_cnt_r + 8'd1;
        end else begin
            settle_cnt_r <= settle_cnt_r;
        end
    end

    // Classify a sample: one slot write enable per digit, or an anode error.
    always_comb begin
        slot_we_s    = 8'h00;
        err_sample_s = 1'b0;
        if (sample_s) begin
            if (single_low(anodes_sync_r)) begin
                slot_we_s = frame_done_s ? 8'h00 : ~anodes_sync_r;
            end else begin
                err_sample_s = 1'b1;
            end
        end else begin
            slot_we_s    = 8'h00;
            err_sample_s = 1'b0;
        end
    end

    // Capture mask, error pulse and shadow code slots.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            capture_mask_r <= 8'h00;
            anode_error_r  <= 1'b0;
            shadow_codes_r <= CODES_BLANK;
        end else begin
            anode_error_r <= err_sample_s;
            if (frame_done_s || err_sample_s) begin
                capture_mask_r <= 8'h00;
            end else begin
                capture_mask_r <= capture_mask_r | slot_we_s;
            end
            for (int i = 0; i < 8; i++) begin
                if (slot_we_s[i]) begin
                    shadow_codes_r[i*5 +: 5] <= code_s;
                end else begin
                    shadow_codes_r[i*5 +: 5] <= shadow_codes_r[i*5 +: 5];
                end
            end
        end
    end

    // Frame handshake: load on completion when the output is free or being
    // accepted this cycle, otherwise drop the new frame and flag overrun.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            frame_valid_r <= 1'b0;
            digit_codes_r <= CODES_BLANK;
            overrun_r     <= 1'b0;
        end else if (frame_done_s) begin
            if (frame_load_s) begin
                digit_codes_r <= shadow_codes_r;
                frame_valid_r <= 1'b1;
            end else begin
                overrun_r     <= 1'b1;
            end
        end else if (frame_valid_r && frame_ready) begin
            frame_valid_r <= 1'b0;
        end else begin
            frame_valid_r <= frame_valid_r;
        end
    end

`ifdef SEG_SCAN_DP_CAPTURE_EN
    logic [7:0] shadow_dp_r;
    logic [7:0] dp_bits_r;

    // Decimal-point shadow slots, written alongside the code slots.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            shadow_dp_r <= 8'h00;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (slot_we_s[i]) begin
                    shadow_dp_r[i] <= ~cathodes_sync_r[0];
                end else begin
                    shadow_dp_r[i] <= shadow_dp_r[i];
                end
            end
        end
    end

    // Decimal-point output register, loaded with the frame.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            dp_bits_r <= 8'h00;
        end else if (frame_load_s) begin
            dp_bits_r <= shadow_dp_r;
        end else begin
            dp_bits_r <= dp_bits_r;
        end
    end

    assign dp_bits = dp_bits_r;
`else
    assign dp_bits = 8'h00;
`endif

    assign frame_valid = frame_valid_r;
    assign digit_codes = digit_codes_r;
    assign anode_error = anode_error_r;
    assign overrun     = overrun_r;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_decoder
//
// Self-checking bench for seg_scan_decoder (SETTLE_CYCLES = 16).  A
// behavioural model tracks the two-cycle input latency, the run length of
// each stable anode value, the captured digits and the frame handshake; every
// cycle the DUT outputs are compared with it.  Directed scenarios add fixed
// expectations, then a randomized scan phase runs against the model.
// ---------------------------------------------------------------------------
module tb_seg_scan_decoder;

    localparam int SETTLE = 16;

    // Active-low cathode bytes (dp off) for codes 0..12.
    localparam logic [7:0] SEG_TBL [13] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'hFF, 8'hFD, 8'h61
    };

    logic        clk_100MHz = 1'b0;
    logic        reset      = 1'b0;
    logic [7:0]  anodes     = 8'hFF;
    logic [7:0]  cathodes   = 8'hFF;
    logic        frame_ready = 1'b0;
    logic        frame_valid;
    logic [39:0] digit_codes;
    logic [7:0]  dp_bits;
    logic        anode_error;
    logic        overrun;

    seg_scan_decoder #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk_100MHz  (clk_100MHz),
        .reset       (reset),
        .anodes      (anodes),
        .cathodes    (cathodes),
        .frame_ready (frame_ready),
        .frame_valid (frame_valid),
        .digit_codes (digit_codes),
        .dp_bits     (dp_bits),
        .anode_error (anode_error),
        .overrun     (overrun)
    );

    // 100 MHz clock.
    always #5 clk_100MHz = ~clk_100MHz;

    int n_compared   = 0;
    int n_mismatched = 0;
    int err_pulses   = 0;
    int valid_rises  = 0;
    logic prev_valid = 1'b0;

    // Single comparison point for the whole bench.
    task automatic check_eq(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_ha1, m_ha2, m_hc1, m_hc2;
    logic [7:0] m_prev_seen;
    int         m_run;
    logic [7:0] m_mask;
    int         m_shadow [8];
    logic       m_shadow_dp [8];
    int         m_codes [8];
    logic       m_dp [8];
    logic       m_valid, m_err, m_overrun;

    function automatic int ref_decode(input logic [7:0] c);
        for (int k = 0; k < 13; k++) begin
            if ((c | 8'h01) == SEG_TBL[k]) return k;
        end
        return 31;
    endfunction

    function automatic logic [7:0] an_sel(input int d);
        logic [7:0] m;
        m = 8'h01 << d;
        return ~m;
    endfunction

    task automatic model_reset();
        m_ha1 = 8'hFF; m_ha2 = 8'hFF; m_hc1 = 8'hFF; m_hc2 = 8'hFF;
        m_prev_seen = 8'hFF;
        m_run = 0;
        m_mask = 8'h00;
        for (int i = 0; i < 8; i++) begin
            m_shadow[i] = 10; m_shadow_dp[i] = 1'b0;
            m_codes[i]  = 10; m_dp[i]        = 1'b0;
        end
        m_valid = 1'b0; m_err = 1'b0; m_overrun = 1'b0;
    endtask

    task automatic model_edge(input logic [7:0] a, input logic [7:0] c, input logic rdy);
        logic [7:0] seen_a, seen_c;
        logic       do_sample;
        int         zeros, idx;
        seen_a = m_ha2; seen_c = m_hc2;
        m_ha2 = m_ha1; m_ha1 = a;
        m_hc2 = m_hc1; m_hc1 = c;
        if (seen_a == m_prev_seen) m_run++;
        else m_run = 1;
        m_prev_seen = seen_a;
        do_sample = (seen_a != 8'hFF) && (m_run == SETTLE);
        m_err = 1'b0;
        if (m_mask == 8'hFF) begin
            if (!m_valid || rdy) begin
                for (int i = 0; i < 8; i++) begin
                    m_codes[i] = m_shadow[i];
                    m_dp[i]    = m_shadow_dp[i];
                end
                m_valid = 1'b1;
            end else begin
                m_overrun = 1'b1;
            end
            m_mask = 8'h00;
        end else begin
            if (m_valid && rdy) m_valid = 1'b0;
            if (do_sample) begin
                zeros = 0; idx = 0;
                for (int i = 0; i < 8; i++) begin
                    if (!seen_a[i]) begin zeros++; idx = i; end
                end
                if (zeros == 1) begin
                    m_shadow[idx] = ref_decode(seen_c);
`ifdef SEG_SCAN_DP_CAPTURE_EN
                    m_shadow_dp[idx] = ~seen_c[0];
`endif
                    m_mask[idx] = 1'b1;
                end else begin
                    m_err  = 1'b1;
                    m_mask = 8'h00;
                end
            end
        end
    endtask

    function automatic logic [39:0] model_codes();
        logic [39:0] p;
        for (int i = 0; i < 8; i++) p[5*i +: 5] = 5'(m_codes[i]);
        return p;
    endfunction

    function automatic logic [7:0] model_dp();
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = m_dp[i];
        return p;
    endfunction

    // One clock: advance the model with the inputs the DUT sees, then compare.
    task automatic tick();
        @(posedge clk_100MHz);
        if (!reset) model_reset();
        else model_edge(anodes, cathodes, frame_ready);
        #1;
        check_eq("frame_valid", {39'd0, frame_valid}, {39'd0, m_valid});
        check_eq("anode_error", {39'd0, anode_error}, {39'd0, m_err});
        check_eq("overrun", {39'd0, overrun}, {39'd0, m_overrun});
        check_eq("digit_codes", digit_codes, model_codes());
        check_eq("dp_bits", {32'd0, dp_bits}, {32'd0, model_dp()});
        if (anode_error) err_pulses++;
        if (frame_valid && !prev_valid) valid_rises++;
        prev_valid = frame_valid;
    endtask

    task automatic dwell(input logic [7:0] a, input logic [7:0] c, input int n);
        anodes = a; cathodes = c;
        repeat (n) tick();
    endtask

    task automatic scan_range(input int lo, input int hi, input logic [7:0] c);
        for (int d = lo; d <= hi; d++) dwell(an_sel(d), c, 20);
    endtask

    task automatic accept();
        frame_ready = 1'b1; tick();
        frame_ready = 1'b0; tick();
    endtask

    logic [39:0] exp_codes;
    logic [39:0] blank_codes;

    initial begin
        blank_codes = {8{5'd10}};
        model_reset();

        // Reset state.
        reset = 1'b0;
        repeat (3) tick();
        check_eq("rst_valid", {39'd0, frame_valid}, 40'd0);
        check_eq("rst_codes", digit_codes, blank_codes);
        check_eq("rst_dp", {32'd0, dp_bits}, 40'd0);
        reset = 1'b1;
        dwell(8'hFF, 8'hFF, 3);

        // Scan of '0' on every digit.
        err_pulses = 0; valid_rises = 0;
        scan_range(0, 7, 8'h03);
        dwell(8'hFF, 8'hFF, 5);
        check_eq("s1_valid", {39'd0, frame_valid}, 40'd1);
        check_eq("s1_codes", digit_codes, 40'd0);
        check_eq("s1_rises", 40'(valid_rises), 40'd1);
        check_eq("s1_errors", 40'(err_pulses), 40'd0);
        accept();
        check_eq("s1_accepted", {39'd0, frame_valid}, 40'd0);

        // '5' on AN3 only, other digits blank.
        for (int d = 0; d < 8; d++) dwell(an_sel(d), (d == 3) ? 8'h49 : 8'hFF, 20);
        dwell(8'hFF, 8'hFF, 5);
        exp_codes = blank_codes;
        exp_codes[15 +: 5] = 5'd5;
        check_eq("s2_valid", {39'd0, frame_valid}, 40'd1);
        check_eq("s2_codes", digit_codes, exp_codes);
        check_eq("s2_dp", {32'd0, dp_bits}, 40'd0);
        accept();

        // AN2 held too briefly: no frame until a full hold.
        for (int d = 0; d < 8; d++) dwell(an_sel(d), 8'h03, (d == 2) ? 10 : 20);
        dwell(8'hFF, 8'hFF, 5);
        check_eq("s3_no_frame", {39'd0, frame_valid}, 40'd0);
        dwell(an_sel(2), 8'h9F, 20);
        dwell(8'hFF, 8'hFF, 5);
        exp_codes = 40'd0;
        exp_codes[10 +: 5] = 5'd1;
        check_eq("s3_valid", {39'd0, frame_valid}, 40'd1);
        check_eq("s3_codes", digit_codes, exp_codes);
        accept();

        // Two anodes low: one error pulse and the partial mask is lost.
        err_pulses = 0;
        scan_range(0, 3, 8'h03);
        dwell(8'hFC, 8'h03, 20);
        scan_range(4, 7, 8'h03);
        dwell(8'hFF, 8'hFF, 5);
        check_eq("s4_err_pulses", 40'(err_pulses), 40'd1);
        check_eq("s4_no_frame", {39'd0, frame_valid}, 40'd0);
        scan_range(0, 3, 8'h03);
        dwell(8'hFF, 8'hFF, 5);
        check_eq("s4_valid", {39'd0, frame_valid}, 40'd1);
        accept();

        // Two scans without acceptance: first frame held, overrun set.
        for (int d = 0; d < 8; d++) dwell(an_sel(d), SEG_TBL[d], 20);
        scan_range(0, 7, 8'h01);
        dwell(8'hFF, 8'hFF, 5);
        for (int i = 0; i < 8; i++) exp_codes[5*i +: 5] = 5'(i);
        check_eq("s5_valid", {39'd0, frame_valid}, 40'd1);
        check_eq("s5_codes", digit_codes, exp_codes);
        check_eq("s5_overrun", {39'd0, overrun}, 40'd1);
        accept();

        // Reset mid-scan discards partial captures.
        scan_range(0, 3, 8'h03);
        reset = 1'b0;
        repeat (3) tick();
        check_eq("s6_rst_valid", {39'd0, frame_valid}, 40'd0);
        check_eq("s6_rst_codes", digit_codes, blank_codes);
        check_eq("s6_rst_overrun", {39'd0, overrun}, 40'd0);
        reset = 1'b1;
        scan_range(4, 7, 8'h03);
        dwell(8'hFF, 8'hFF, 5);
        check_eq("s6_no_frame", {39'd0, frame_valid}, 40'd0);
        scan_range(0, 7, 8'h03);
        dwell(8'hFF, 8'hFF, 5);
        check_eq("s6_valid", {39'd0, frame_valid}, 40'd1);
        accept();

        // Randomized scanning with random consumer back-pressure.
        for (int seg = 0; seg < 300; seg++) begin
            int kind, len;
            logic [7:0] a, c;
            kind = $urandom_range(0, 9);
            len  = $urandom_range(1, 30);
            if (kind < 7)       a = an_sel($urandom_range(0, 7));
            else if (kind == 7) a = 8'hFF;
            else                a = 8'($urandom_range(0, 254));
            if ($urandom_range(0, 4) < 3) c = SEG_TBL[$urandom_range(0, 12)] & {7'h7F, 1'($urandom_range(0, 1))};
            else                          c = 8'($urandom_range(0, 255));
            anodes = a; cathodes = c;
            repeat (len) begin
                frame_ready = ($urandom_range(0, 3) == 0);
                tick();
            end
        end
        frame_ready = 1'b0;
        dwell(8'hFF, 8'hFF, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter SETTLE_CYCLES, default 16: consecutive stable cycles an anode selection must hold before the cathodes are sampled; legal range 2..255.
REQ-002 clk_100MHz  input  1  single system clock; all logic on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 anodes  input  8  multiplexed display anodes, active-low, AN7..AN0; driven by the display controller.
REQ-005 cathodes  input  8  segment lines, active-low, bit7..bit0 = a,b,c,d,e,f,g,dp.
REQ-006 frame_ready  input  1  consumer accepts the held frame when high while frame_valid is high.
REQ-007 frame_valid  output  1  a complete 8-digit frame is held on digit_codes/dp_bits.
REQ-008 digit_codes  output  40  5-bit code per digit; [5i+4:5i] belongs to AN(i).
REQ-009 dp_bits  output  8  decimal-point state per digit, 1 = lit.
REQ-010 anode_error  output  1  one-cycle pulse: more than one anode was low when a sample was due.
REQ-011 overrun  output  1  sticky: a completed frame was dropped because the previous frame was still pending.

Function
REQ-012 anodes and cathodes SHALL pass through a 2-flop synchronizer; all further behaviour uses the synchronized values.
REQ-013 FSM states: IDLE, SETTLE, HOLD.
- IDLE: stays while synchronized anodes == 8'hFF. Any other value loads the settle counter with 1 and moves to SETTLE.
- SETTLE: counter increments while anodes are unchanged. A change reloads the counter with 1. A change to 8'hFF returns to IDLE.
- When the count reaches SETTLE_CYCLES, the sample is taken on that cycle and the FSM moves to HOLD.
- HOLD: waits for an anode change, then goes to SETTLE, or to IDLE if the new value is 8'hFF.
REQ-014 On sample, if exactly one anode bit is 0: decode cathodes into that digit's slot and set that bit in an 8-bit capture mask. If two or more bits are 0: pulse anode_error, clear the capture mask, write no slot, go to HOLD.
REQ-015 Decode table (a..g lit pattern, dp ignored):
- standard 0-9 -> codes 0-9. 6 includes a. 7 = a,b,c. 9 includes d.
- all segments off -> 10 (blank).
- g only -> 11 (dash).
- a,d,e,f,g -> 12 ('E').
- any other pattern -> 31.
REQ-016 A repeated capture of the same digit before the mask is full SHALL overwrite that slot.
REQ-017 The cycle after the mask reaches 8'hFF:
- if frame_valid is low: copy the shadow slots to digit_codes/dp_bits, assert frame_valid, clear the mask.
- otherwise: keep the held outputs, set overrun, clear the mask.
REQ-018 frame_valid SHALL stay high, with digit_codes/dp_bits stable, until a cycle where frame_ready is high; it drops the next cycle.
REQ-019 Simultaneous accept and new-frame completion on the same cycle SHALL load the new frame and keep frame_valid high, with no overrun.
REQ-020 frame_ready while frame_valid is low SHALL have no effect.

Reset
REQ-021 While reset is low:
- FSM in IDLE.
- Counter, capture mask, shadow slots and synchronizers cleared; synchronizers preset to 8'hFF.
- Outputs: frame_valid 0, digit_codes all slots 10 (blank), dp_bits 0, anode_error 0, overrun 0.
REQ-022 Reset asserted mid-frame SHALL discard partial captures. The first frame after release requires all 8 digits to be captured anew.

Configuration
REQ-023 Macro SEG_SCAN_DP_CAPTURE_EN:
- defined: dp_bits[i] is loaded with the inverted cathodes[0] at each capture of digit i, using the same path as the code.
- undefined: no dp storage is synthesized, dp_bits is constant 0, and the decode is unchanged.

Verification
REQ-024 The bench SHALL cover these directed scenarios (SETTLE_CYCLES=16):
- Scan AN0..AN7, 20 cycles each, cathodes 8'h03 ('0') -> one frame_valid, all codes 0, no anode_error.
- AN3 with cathodes 8'h49 ('5'), others 8'hFF -> slot 3 = 5, other slots = 10; with the macro defined dp_bits = 0.
- AN2 held for only 10 cycles -> no capture for digit 2, and no frame until a full 16-cycle hold occurs.
- anodes 8'hFC for 20 cycles -> one anode_error pulse and capture mask cleared.
- frame_ready held 0 across two full scans -> first frame held unchanged and overrun = 1.
- reset pulsed low mid-scan -> outputs return to reset values, and the next frame needs all 8 digits.
